// File: rtl/freq_gate_counter_if.sv
// Bus between the frequency counter front end and its consumers.
// master: drives signal/period, observes result; slave: the counter.
interface freq_gate_counter_if #(
  parameter int PERIOD_W = 16
);
  logic                signal;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          ten_count;
  logic [3:0]          unit_count;
  logic                load;
  logic                overflow;

  modport master (
    output signal,
    output period,
    input  ten_count,
    input  unit_count,
    input  load,
    input  overflow
  );

  modport slave (
    input  signal,
    input  period,
    output ten_count,
    output unit_count,
    output load,
    output overflow
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated two-digit BCD edge counter with synchroniser and load strobe.
// Ports: clk, reset (sync, active high), bus (slave): signal, period
// in; ten_count, unit_count, load, overflow out. Macro FREQ_SATURATE_EN
// selects saturate-at-99 with overflow flag; otherwise count wraps.
module freq_gate_counter #(
  parameter int PERIOD_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  freq_gate_counter_if.slave   bus
);

  typedef enum logic [0:0] {
    SETTLE,
    COUNT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          settle_cnt;
  logic                sync1;
  logic                sync2;
  logic                sync_prev;
  logic                rise;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] period_eff;
  logic [3:0]          ones;
  logic [3:0]          tens;
  logic [3:0]          ones_n;
  logic [3:0]          tens_n;
  logic                counting;
  logic                settle_done;
  logic                win_end;
  logic                at_max;

  assign rise = sync2 & ~sync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= bus.signal;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SETTLE: begin
        if (settle_cnt == 2'd3) begin
          state_nxt = COUNT;
        end
      end
      COUNT: state_nxt = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      settle_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end

  assign counting    = (state == COUNT);
  assign settle_done = (state == SETTLE) &&
                       (state_nxt == COUNT);
  assign win_end     = counting &&
    (timer == period_reg - PERIOD_W'(1));
  assign period_eff  = (bus.period == '0) ?
    PERIOD_W'(1) : bus.period;
  assign at_max      = (ones == 4'd9) &&
                       (tens == 4'd9);

  // Next BCD value including a rise seen in this cycle, so the
  // window-end capture never drops the last edge.
  always_comb begin
    ones_n = ones;
    tens_n = tens;
    if (counting && rise) begin
      if (ones != 4'd9) begin
        ones_n = ones + 4'd1;
      end else if (tens != 4'd9) begin
        ones_n = 4'd0;
        tens_n = tens + 4'd1;
      end else begin
`ifdef FREQ_SATURATE_EN
        ones_n = 4'd9;
        tens_n = 4'd9;
`else
        ones_n = 4'd0;
        tens_n = 4'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer          <= '0;
      period_reg     <= PERIOD_W'(1);
      ones           <= 4'd0;
      tens           <= 4'd0;
      bus.ten_count  <= 4'd0;
      bus.unit_count <= 4'd0;
      bus.load       <= 1'b0;
    end else begin
      bus.load <= 1'b0;
      if (settle_done) begin
        timer      <= '0;
        period_reg <= period_eff;
      end else if (win_end) begin
        bus.ten_count  <= tens_n;
        bus.unit_count <= ones_n;
        bus.load       <= 1'b1;
        ones           <= 4'd0;
        tens           <= 4'd0;
        timer          <= '0;
        period_reg     <= period_eff;
      end else if (counting) begin
        ones  <= ones_n;
        tens  <= tens_n;
        timer <= timer + PERIOD_W'(1);
      end
    end
  end

`ifdef FREQ_SATURATE_EN
  logic ovf;
  logic ovf_n;

  assign ovf_n = ovf | (counting && rise && at_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf          <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (win_end) begin
      bus.overflow <= ovf_n;
      ovf          <= 1'b0;
    end else if (counting) begin
      ovf <= ovf_n;
    end
  end
`else
  logic unused_max;
  assign unused_max   = at_max;
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: window model on sampled
// input history feeds a queue; a negedge monitor checks each load.
module tb_freq_gate_counter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  freq_gate_counter_if #(.PERIOD_W(16)) bus ();

  freq_gate_counter #(.PERIOD_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int ten;
    int unit;
    int ov;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: n = edges since the last reset edge; h0..h2 = input
  // samples at edges n-1..n-3. Windows open at cycle 4.
  int n;
  int h0, h1, h2;
  int cnt;
  int wstart;
  int wlen;

  function automatic exp_t mk(int c, int cyc);
    exp_t e;
`ifdef FREQ_SATURATE_EN
    int v;
    v = (c > 99) ? 99 : c;
    e.ten  = v / 10;
    e.unit = v % 10;
    e.ov   = (c > 99) ? 1 : 0;
`else
    e.ten  = (c % 100) / 10;
    e.unit = c % 10;
    e.ov   = 0;
`endif
    e.cyc = cyc;
    return e;
  endfunction

  function automatic int eff(int p);
    return (p == 0) ? 1 : p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      h0 = 0; h1 = 0; h2 = 0;
      cnt = 0;
      wstart = 4;
      wlen = 1;
    end else begin
      n = n + 1;
      if (n - 1 >= 4 && h1 == 1 && h2 == 0)
        cnt = cnt + 1;
      if (n == 4) begin
        wstart = 4;
        wlen = eff(int'(bus.period));
      end else if (n > 4 && n == wstart + wlen) begin
        q.push_back(mk(cnt, n));
        cnt = 0;
        wstart = n;
        wlen = eff(int'(bus.period));
      end
      h2 = h1;
      h1 = h0;
      h0 = int'(bus.signal);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.load) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_load cyc=%0d got=%0d/%0d ov=%0d req=none",
                 n, bus.ten_count, bus.unit_count, bus.overflow);
      end else begin
        e = q.pop_front();
        if (e.cyc != n || e.ten != int'(bus.ten_count) ||
            e.unit != int'(bus.unit_count) ||
            e.ov != int'(bus.overflow)) begin
          errors++;
          $display("FAIL load got cyc=%0d %0d/%0d ov=%0d req cyc=%0d %0d/%0d ov=%0d",
                   n, bus.ten_count, bus.unit_count, bus.overflow,
                   e.cyc, e.ten, e.unit, e.ov);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= n) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missing_load at cyc=%0d got load=0 req %0d/%0d ov=%0d",
               n, e.ten, e.unit, e.ov);
    end
  end

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) @(negedge clk);
    checks++;
    if (bus.ten_count != 4'd0 || bus.unit_count != 4'd0 ||
        bus.load != 1'b0 || bus.overflow != 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %0d/%0d load=%0d ov=%0d req 0/0 0 0",
               bus.ten_count, bus.unit_count, bus.load, bus.overflow);
    end
    reset = 1'b0;
  endtask

  task automatic run_toggle(input int cycles, input int half);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (i % half == half - 1) bus.signal = ~bus.signal;
    end
  endtask

  task automatic run_hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run_rand(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.signal = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0)
        bus.period = 16'($urandom_range(0, 40));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.signal = 1'b1;
    bus.period = 16'd10;
    @(negedge clk);
    // signal high through reset, period 10: first load cycle 14, 0/0
    do_reset(2);
    run_hold(40);
    // basic count: 10 edges per 100-cycle window
    bus.signal = 1'b0;
    bus.period = 16'd100;
    do_reset(1);
    run_toggle(350, 5);
    // over-range window: 250 edges per 1000 cycles
    bus.signal = 1'b0;
    bus.period = 16'd1000;
    do_reset(1);
    run_toggle(2100, 2);
    // single rise reaching the last cycle of a 20-cycle window
    bus.signal = 1'b0;
    bus.period = 16'd20;
    do_reset(1);
    run_hold(21);
    bus.signal = 1'b1;
    run_hold(60);
    // reset mid-window
    bus.signal = 1'b0;
    bus.period = 16'd10;
    do_reset(1);
    run_toggle(18, 2);
    do_reset(1);
    run_toggle(30, 2);
    // period change 50 -> 30 inside the first window
    bus.signal = 1'b0;
    bus.period = 16'd50;
    do_reset(1);
    run_toggle(30, 3);
    bus.period = 16'd30;
    run_toggle(150, 3);
    // zero period: load every cycle
    bus.period = 16'd0;
    do_reset(1);
    run_rand(30);
    // randomised mix
    bus.period = 16'($urandom_range(0, 40));
    do_reset(1);
    run_rand(2000);
    run_hold(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending req 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
